cmp_capture_bank: RTL and testbench
===================================

Name: cmp_capture_bank

Overview:
Parametrised multi-channel compare-and-capture register bank. It generalises single-bit conditional capture (a > b), hold, and AND-accumulate registers into CH channels of WIDTH bits, with selectable MAX/MIN/AND/OR reduction over a window of WINDOW valid samples. At each window end it publishes one result set plus a done pulse. It sits between sample sources (sensor/ADC front ends) and the stats/register interface.

Parameters:
WIDTH, 8, bits per channel sample (>=1)
CH, 4, number of channels (>=1)
WINDOW, 16, valid samples per reduction window (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous window abort/restart
mode  in  2  reduction select: 0=MAX, 1=MIN, 2=AND, 3=OR
in_valid  in  1  sample qualifier
in_data  in  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
out_data  out  CH*WIDTH  published per-channel results, same packing
out_idx  out  CH*IW  per-channel in-window position of the winning sample (MAX/MIN); IW = max(1, clog2(WINDOW))
out_valid  out  1  one-cycle pulse: new result set published
sample_cnt  out  IW  number of samples accepted in the current window

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0: out_data=0, out_idx=0, out_valid=0, sample_cnt=0, all accumulators=0, first flag=1, mode_q=0.
- Priority each edge: rst > clear > in_valid.
- Accept: a sample is accepted on a rising edge with in_valid=1 and clear=0.
- First sample of a window (first=1):
  - mode_q <= mode.
  - acc[i] <= in_data[i] for every channel, regardless of mode.
  - idx[i] <= 0.
  - first <= 0.
- mode is sampled only at the first sample. Changes mid-window are ignored until the next window.
- Subsequent samples, unsigned compare, per channel independently:
  - MAX: if x > acc then acc <= x, idx <= sample_cnt. Strict compare: ties keep the earliest sample.
  - MIN: if x < acc then acc <= x, idx <= sample_cnt. Ties keep the earliest sample.
  - AND: acc <= acc & x.
  - OR: acc <= acc | x.
  - AND/OR leave idx at 0.
  - Otherwise acc holds its value.
- Counter: sample_cnt increments on each accepted sample.
- Window end: on the edge accepting a sample with sample_cnt == WINDOW-1:
  - out_data/out_idx <= the updated values including this sample.
  - out_valid <= 1 for exactly one cycle.
  - sample_cnt <= 0, first <= 1.
- Latency: results visible, with out_valid=1, in the cycle after the last sample's accepting edge.
- out_data/out_idx hold their values between publications. They are never cleared except by rst.
- No accepted sample: all state holds, out_valid=0.
- Gaps in in_valid are allowed and do not affect results.
- clear=1: sample_cnt <= 0, first <= 1, out_valid <= 0, out_data/out_idx hold.
  - A sample presented in the same cycle is dropped.
  - A partially accumulated window is discarded and never published.
- WINDOW=1: every accepted sample is published. out_data = in_data and out_idx = 0 the next cycle, and out_valid pulses on every accepted sample (back-to-back pulses permitted).
- Back-to-back windows: a sample accepted in the cycle out_valid is high starts the new window normally.
- Reset mid-window: all state returns to reset values immediately (asynchronously). The partial window is lost.
- No overflow is possible. Results are always exactly WIDTH bits per channel.

Test Plan:
1. Reset check (WIDTH=8, CH=4, WINDOW=4): assert rst=0 mid-stream -> all outputs 0 immediately. Release, idle -> out_valid never asserts.
2. MAX mode, ch0 samples 3,9,9,5 -> one cycle after 4th sample: out_valid=1 for 1 cycle, ch0 out_data=9, out_idx=1 (tie keeps earliest), sample_cnt=0.
3. MIN mode, ch1 samples 0x80,0x10,0xFF,0x10 with in_valid gaps between them -> ch1 out_data=0x10, out_idx=1. Switching mode to OR after sample 2 has no effect.
4. AND/OR modes, ch2 samples 0xF0,0x3C,0xFF,0x30 -> AND gives 0x30, idx=0. OR on the same stream gives 0xFF.
5. clear after 2 samples, asserted together with in_valid -> no out_valid; sample_cnt=0. Next 4 samples 1,2,3,4 in MAX give out_data=4, out_idx=3, and the previous out_data is held until then.
6. WINDOW=1 build, continuous in_valid with 7,2,5 -> out_valid high 3 consecutive cycles, out_data 7,2,5, out_idx=0 each.

Source files
------------

// File: rtl/cmp_capture_bank.sv
// Multi-channel compare-and-capture bank: MAX/MIN/AND/OR reduction over a
// window of valid samples, publishing one result set per window.
module cmp_capture_bank #(
    parameter int WIDTH  = 8,
    parameter int CH     = 4,
    parameter int WINDOW = 16,
    localparam int IW    = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    input  logic [CH*WIDTH-1:0] in_data,
    output logic [CH*WIDTH-1:0] out_data,
    output logic [CH*IW-1:0]    out_idx,
    output logic                out_valid,
    output logic [IW-1:0]       sample_cnt
);

    typedef enum logic [1:0] {
        MODE_MAX = 2'd0,
        MODE_MIN = 2'd1,
        MODE_AND = 2'd2,
        MODE_OR  = 2'd3
    } mode_e;

    mode_e            mode_q;
    logic             first;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] acc    [CH];
    logic [IW-1:0]    idx    [CH];
    logic [WIDTH-1:0] acc_nx [CH];
    logic [IW-1:0]    idx_nx [CH];
    logic [CH*WIDTH-1:0] data_pk;
    logic [CH*IW-1:0]    idx_pk;

    assign accept = in_valid & ~clear;
    assign last   = (sample_cnt == IW'(WINDOW - 1));

    // Per-channel update assuming the current input is accepted.
    always_comb begin
        data_pk = '0;
        idx_pk  = '0;
        for (int i = 0; i < CH; i++) begin
            acc_nx[i] = acc[i];
            idx_nx[i] = idx[i];
            if (first) begin
                acc_nx[i] = in_data[i*WIDTH +: WIDTH];
                idx_nx[i] = '0;
            end else begin
                unique case (mode_q)
                    MODE_MAX: begin
                        if (in_data[i*WIDTH +: WIDTH] > acc[i]) begin
                            acc_nx[i] = in_data[i*WIDTH +: WIDTH];
                            idx_nx[i] = sample_cnt;
                        end
                    end
                    MODE_MIN: begin
                        if (in_data[i*WIDTH +: WIDTH] < acc[i]) begin
                            acc_nx[i] = in_data[i*WIDTH +: WIDTH];
                            idx_nx[i] = sample_cnt;
                        end
                    end
                    MODE_AND: acc_nx[i] = acc[i] & in_data[i*WIDTH +: WIDTH];
                    MODE_OR:  acc_nx[i] = acc[i] | in_data[i*WIDTH +: WIDTH];
                    default:  ;
                endcase
            end
            data_pk[i*WIDTH +: WIDTH] = acc_nx[i];
            idx_pk[i*IW +: IW]        = idx_nx[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                acc[i] <= '0;
                idx[i] <= '0;
            end
            mode_q     <= MODE_MAX;
            first      <= 1'b1;
            sample_cnt <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            first      <= 1'b1;
            out_valid  <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < CH; i++) begin
                acc[i] <= acc_nx[i];
                idx[i] <= idx_nx[i];
            end
            if (first) begin
                mode_q <= mode_e'(mode);
            end
            if (last) begin
                out_data   <= data_pk;
                out_idx    <= idx_pk;
                out_valid  <= 1'b1;
                sample_cnt <= '0;
                first      <= 1'b1;
            end else begin
                out_valid  <= 1'b0;
                sample_cnt <= sample_cnt + IW'(1);
                first      <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_capture_bank.sv
// Bench for cmp_capture_bank: a WINDOW=4 and a WINDOW=1 build share stimulus
// and are checked against a window-queue reference model.
module tb_cmp_capture_bank;

    localparam int W   = 8;
    localparam int C   = 4;
    localparam int WIN = 4;
    localparam int IW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [C*W-1:0] in_data = '0;

    logic [C*W-1:0]  od4;
    logic [C*IW-1:0] oi4;
    logic            ov4;
    logic [IW-1:0]   sc4;
    logic [C*W-1:0]  od1;
    logic [C-1:0]    oi1;
    logic            ov1;
    logic [0:0]      sc1;

    always #5 clk = ~clk;

    cmp_capture_bank #(.WIDTH(W), .CH(C), .WINDOW(WIN)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_data(in_data),
        .out_data(od4), .out_idx(oi4), .out_valid(ov4),
        .sample_cnt(sc4)
    );

    cmp_capture_bank #(.WIDTH(W), .CH(C), .WINDOW(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_data(in_data),
        .out_data(od1), .out_idx(oi1), .out_valid(ov1),
        .sample_cnt(sc1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [C*W-1:0]  win[$];
    logic [1:0]      wmode;
    logic [C*W-1:0]  e_data;
    logic [C*IW-1:0] e_idx;
    logic            e_valid;
    int              e_cnt;
    logic [C*W-1:0]  e1_data;
    logic            e1_valid;

    task automatic model_reset();
        win.delete();
        wmode    = 2'd0;
        e_data   = '0;
        e_idx    = '0;
        e_valid  = 1'b0;
        e_cnt    = 0;
        e1_data  = '0;
        e1_valid = 1'b0;
    endtask

    // Reduce a full window: MAX/MIN pick the extreme, index = first occurrence.
    task automatic publish();
        for (int ch = 0; ch < C; ch++) begin
            logic [W-1:0] r;
            logic [W-1:0] v;
            int k;
            r = win[0][ch*W +: W];
            for (int s = 1; s < win.size(); s++) begin
                v = win[s][ch*W +: W];
                case (wmode)
                    2'd0: r = (v > r) ? v : r;
                    2'd1: r = (v < r) ? v : r;
                    2'd2: r = r & v;
                    default: r = r | v;
                endcase
            end
            k = 0;
            if (wmode < 2'd2) begin
                for (int s = win.size() - 1; s >= 0; s--)
                    if (win[s][ch*W +: W] == r) k = s;
            end
            e_data[ch*W +: W]  = r;
            e_idx[ch*IW +: IW] = IW'(k);
        end
    endtask

    task automatic model_step(input logic v, input logic c,
                              input logic [1:0] m, input logic [C*W-1:0] d);
        e1_valid = v & ~c;
        if (v && !c) e1_data = d;
        if (c) begin
            win.delete();
            e_valid = 1'b0;
            e_cnt   = 0;
        end else if (v) begin
            if (win.size() == 0) wmode = m;
            win.push_back(d);
            if (win.size() == WIN) begin
                publish();
                win.delete();
                e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
            e_cnt = win.size();
        end else begin
            e_valid = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_valid"}, ov4, e_valid);
        check({tag, "_cnt"}, sc4, e_cnt);
        check({tag, "_data"}, od4, e_data);
        check({tag, "_idx"}, oi4, e_idx);
        check({tag, "_w1valid"}, ov1, e1_valid);
        check({tag, "_w1data"}, od1, e1_data);
        check({tag, "_w1idx"}, oi1, 0);
        check({tag, "_w1cnt"}, sc1, 0);
    endtask

    task automatic cycle(input logic v, input logic c, input logic [1:0] m,
                         input logic [C*W-1:0] d, input string tag);
        in_valid = v;
        clear    = c;
        mode     = m;
        in_data  = d;
        @(posedge clk);
        model_step(v, c, m, d);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        model_reset();
        compare(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [C*W-1:0] rep(input logic [W-1:0] x);
        return {C{x}};
    endfunction

    function automatic logic [C*W-1:0] rnd_data();
        logic [C*W-1:0] d;
        for (int ch = 0; ch < C; ch++) begin
            if ($urandom_range(0, 1) == 0)
                d[ch*W +: W] = W'($urandom_range(0, 3));
            else
                d[ch*W +: W] = W'($urandom);
        end
        return d;
    endfunction

    logic [C*W-1:0] d;
    logic [W-1:0] t_max [4];
    logic [W-1:0] t_min [4];
    logic [W-1:0] t_ao  [4];

    initial begin
        t_max = '{8'd3, 8'd9, 8'd9, 8'd5};
        t_min = '{8'h80, 8'h10, 8'hFF, 8'h10};
        t_ao  = '{8'hF0, 8'h3C, 8'hFF, 8'h30};
        model_reset();
        #12;
        compare("reset");
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-stream, then idle must not publish
        cycle(1'b1, 1'b0, 2'd0, rep(8'h11), "pre_rst0");
        cycle(1'b1, 1'b0, 2'd0, rep(8'h22), "pre_rst1");
        #2;
        do_reset("rst_mid");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 2'd0, '0, "idle");

        // MAX with a tie on ch0
        for (int s = 0; s < 4; s++) begin
            d = rnd_data();
            d[7:0] = t_max[s];
            cycle(1'b1, 1'b0, 2'd0, d, "max");
        end
        check("max_ch0_data", od4[7:0], 8'd9);
        check("max_ch0_idx", oi4[1:0], 2'd1);
        check("max_pulse", ov4, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, '0, "max_after");
        check("max_pulse_end", ov4, 1'b0);

        // MIN on ch1 with gaps; mode switches to OR mid-window
        for (int s = 0; s < 4; s++) begin
            d = rnd_data();
            d[15:8] = t_min[s];
            cycle(1'b1, 1'b0, (s < 2) ? 2'd1 : 2'd3, d, "min");
            if (s < 3) cycle(1'b0, 1'b0, 2'd3, rnd_data(), "min_gap");
        end
        check("min_ch1_data", od4[15:8], 8'h10);
        check("min_ch1_idx", oi4[3:2], 2'd1);

        // AND then OR on ch2
        for (int s = 0; s < 4; s++) begin
            d = rnd_data();
            d[23:16] = t_ao[s];
            cycle(1'b1, 1'b0, 2'd2, d, "and");
        end
        check("and_ch2_data", od4[23:16], 8'h30);
        check("and_ch2_idx", oi4[5:4], 2'd0);
        for (int s = 0; s < 4; s++) begin
            d = rnd_data();
            d[23:16] = t_ao[s];
            cycle(1'b1, 1'b0, 2'd3, d, "or");
        end
        check("or_ch2_data", od4[23:16], 8'hFF);

        // Clear discards a partial window; held output until next publish
        cycle(1'b1, 1'b0, 2'd0, rep(8'hEE), "clr_pre0");
        cycle(1'b1, 1'b0, 2'd0, rep(8'hEF), "clr_pre1");
        cycle(1'b1, 1'b1, 2'd0, rep(8'hFE), "clr");
        check("clr_cnt", sc4, 0);
        check("clr_novalid", ov4, 1'b0);
        for (int s = 1; s <= 4; s++)
            cycle(1'b1, 1'b0, 2'd0, rep(W'(s)), "clr_post");
        check("clr_post_data", od4[7:0], 8'd4);
        check("clr_post_idx", oi4[1:0], 2'd3);

        // WINDOW=1 build: consecutive publications
        cycle(1'b1, 1'b0, 2'd0, rep(8'd7), "w1_a");
        check("w1_a_data", od1[7:0], 8'd7);
        cycle(1'b1, 1'b0, 2'd0, rep(8'd2), "w1_b");
        check("w1_b_data", od1[7:0], 8'd2);
        check("w1_b_valid", ov1, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, rep(8'd5), "w1_c");
        check("w1_c_data", od1[7:0], 8'd5);
        check("w1_c_valid", ov1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2;
                do_reset("rnd_rst");
            end
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                  2'($urandom), rnd_data(), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
